// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: handshake bundle between the fetch unit and its controller.
// The master side drives the per-instruction control inputs and observes the PC
// and status. The slave side is the fetch unit itself.
interface pc_fetch_unit_if #(
   parameter int PC_W  = 10,
   parameter int CNT_W = 32
);
   logic             en;
   logic             branch;
   logic             zero;
   logic [31:0]      imm;
   logic             halt_req;
   logic [PC_W-1:0]  pc;
   logic             pc_valid;
   logic             halted;
   logic [CNT_W-1:0] retired;
   logic             fault;

   modport master (
      output en, branch, zero, imm, halt_req,
      input  pc, pc_valid, halted, retired, fault
   );

   modport slave (
      input  en, branch, zero, imm, halt_req,
      output pc, pc_valid, halted, retired, fault
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter stage feeding the instruction memory.
// The PC is word-indexed. Each enabled cycle in RUN retires one instruction
// and advances the PC, either sequentially or by a taken branch (branch & zero).
// Optional feature, macro PC_TRAP_EN: a taken branch whose byte offset is not
// word aligned traps into FAULT instead of retiring.
module pc_fetch_unit #(
   parameter int PC_W     = 10,
   parameter int RESET_PC = 0,
   parameter int CNT_W    = 32
) (
   input logic          clk,
   input logic          rst,
   pc_fetch_unit_if.slave bus
);

`ifdef PC_TRAP_EN
   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT, ST_FAULT} state_t;
`else
   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;
`endif

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic             taken;
   logic [PC_W-1:0]  br_offset;
   logic             unused_imm;

   // The immediate is a byte offset; its word part is bits [PC_W+1:2].
   assign taken      = bus.branch & bus.zero;
   assign br_offset  = bus.imm[PC_W+1:2];
   assign unused_imm = ^{bus.imm[31:PC_W+2], bus.imm[1:0]};

   // State, PC and counter registers; reset overrides every state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_BOOT;
         pc_q      <= PC_W'(RESET_PC);
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         retired_q <= retired_d;
      end
   end

   // Next-state, next-PC and retire logic; halt beats trap beats branch.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (bus.en) begin
               if (bus.halt_req) begin
                  retired_d = retired_q + CNT_W'(1);
                  state_d   = ST_HALT;
               end
`ifdef PC_TRAP_EN
               else if (taken && (bus.imm[1:0] != 2'b00)) begin
                  state_d = ST_FAULT;
               end
`endif
               else begin
                  retired_d = retired_q + CNT_W'(1);
                  pc_d      = taken ? (pc_q + br_offset) : (pc_q + PC_W'(1));
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.pc       = pc_q;
   assign bus.pc_valid = (state_q == ST_RUN);
   assign bus.retired  = retired_q;
`ifdef PC_TRAP_EN
   assign bus.fault    = (state_q == ST_FAULT);
   assign bus.halted   = (state_q == ST_HALT) || (state_q == ST_FAULT);
`else
   assign bus.fault    = 1'b0;
   assign bus.halted   = (state_q == ST_HALT);
`endif

endmodule
